// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : cpu_pkg                                                   |
// | Purpose   : Shared constants for the lab CPU sequencer: ALU codes,    |
// |             state encoding and instruction field positions.           |
// | Revision  : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package cpu_pkg;

   // ALU control codes carried in instr[7:0]
   localparam logic [7:0] ALU_NOP  = 8'h00;
   localparam logic [7:0] ALU_ADD  = 8'h01;
   localparam logic [7:0] ALU_SUB  = 8'h02;
   localparam logic [7:0] ALU_AND  = 8'h03;
   localparam logic [7:0] ALU_OR   = 8'h04;
   localparam logic [7:0] ALU_XOR  = 8'h05;
   localparam logic [7:0] ALU_NOT  = 8'h06;
   localparam logic [7:0] ALU_HALT = 8'hFF;

   // Sequencer state encoding
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_FETCH  = 3'd1;
   localparam state_t ST_DECODE = 3'd2;
   localparam state_t ST_EXEC   = 3'd3;
   localparam state_t ST_WB     = 3'd4;
   localparam state_t ST_HALTED = 3'd5;

   // Instruction word field positions
   localparam int OPA_HI = 11;
   localparam int OPA_LO = 8;
   localparam int OPB_HI = 15;
   localparam int OPB_LO = 12;
   localparam int ALU_HI = 7;
   localparam int ALU_LO = 0;

   // True for codes that launch the ALU and write back a result
   function automatic logic is_alu_op(input logic [7:0] op);
      return (op >= ALU_ADD) && (op <= ALU_NOT);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : pc_reg                                                    |
// | Purpose   : Program counter with synchronous clear and increment.     |
// |             Increment wraps modulo 2^ADDR_W.                          |
// | Ports     : clk, rst_n (async active-low), clr_i (sync clear, wins   |
// |             over inc_i), inc_i (increment enable), count_o (value)    |
// | Revision  : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module pc_reg #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              inc_i,
   output logic [ADDR_W-1:0] count_o
);

   logic [ADDR_W-1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clr_i) begin
         count_q <= '0;
      end else if (inc_i) begin
         count_q <= count_q + ADDR_W'(1);
      end
   end

   assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : cpu_sequencer                                             |
// | Purpose   : Fetch/decode/execute/write-back controller for the 16-bit |
// |             lab CPU. Owns the program counter.                        |
// | Ports     : clk, rst_n        - clock, async active-low reset         |
// |             start             - begin execution at address 0          |
// |             busy/halted       - status                                |
// |             illegal           - sticky undefined-opcode flag          |
// |             pc                - program counter                       |
// |             im_req/addr/ack/data - instruction memory handshake       |
// |             rf_ra/rf_rb       - register-file read addresses          |
// |             alu_op/go/done    - ALU control                           |
// |             rf_we/rf_wa       - register-file write-back              |
// | Revision  : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              halted,
   output logic              illegal,
   output logic [ADDR_W-1:0] pc,
   output logic              im_req,
   output logic [ADDR_W-1:0] im_addr,
   input  logic              im_ack,
   input  logic [15:0]       im_data,
   output logic [3:0]        rf_ra,
   output logic [3:0]        rf_rb,
   output logic [7:0]        alu_op,
   output logic              alu_go,
   input  logic              alu_done,
   output logic              rf_we,
   output logic [3:0]        rf_wa
);

   state_t      state_q, state_d;
   logic [15:0] ir_q, ir_d;
   logic        illegal_q, illegal_d;
   // Marks the first EXEC cycle: alu_go is issued and alu_done ignored
   logic        first_q, first_d;
   logic        pc_clr, pc_inc;

   pc_reg #(
      .ADDR_W (ADDR_W)
   ) u_pc_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (pc_clr),
      .inc_i   (pc_inc),
      .count_o (pc)
   );

   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      illegal_d = illegal_q;
      first_d   = 1'b0;
      pc_clr    = 1'b0;
      pc_inc    = 1'b0;
      case (state_q)
         ST_IDLE, ST_HALTED: begin
            if (start) begin
               pc_clr    = 1'b1;
               illegal_d = 1'b0;
               state_d   = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (im_ack) begin
               ir_d    = im_data;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (is_alu_op(ir_q[ALU_HI:ALU_LO])) begin
               first_d = 1'b1;
               state_d = ST_EXEC;
            end else if (ir_q[ALU_HI:ALU_LO] == ALU_HALT) begin
               state_d = ST_HALTED;
            end else begin
               // Undefined codes flag illegal and otherwise act as NOP
               if (ir_q[ALU_HI:ALU_LO] != ALU_NOP) begin
                  illegal_d = 1'b1;
               end
               pc_inc  = 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_EXEC: begin
            if (!first_q && alu_done) begin
               state_d = ST_WB;
            end
         end
         ST_WB: begin
            pc_inc  = 1'b1;
            state_d = ST_FETCH;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ir_q      <= 16'h0000;
         illegal_q <= 1'b0;
         first_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         illegal_q <= illegal_d;
         first_q   <= first_d;
      end
   end

   assign busy    = (state_q != ST_IDLE) && (state_q != ST_HALTED);
   assign halted  = (state_q == ST_HALTED);
   assign illegal = illegal_q;
   assign im_req  = (state_q == ST_FETCH);
   assign im_addr = pc;
   assign alu_go  = (state_q == ST_EXEC) && first_q;
   assign rf_we   = (state_q == ST_WB);
   assign rf_ra   = ir_q[OPA_HI:OPA_LO];
   assign rf_rb   = ir_q[OPB_HI:OPB_LO];
   assign alu_op  = ir_q[ALU_HI:ALU_LO];
   assign rf_wa   = ir_q[OPA_HI:OPA_LO];

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_cpu_sequencer                                          |
// | Purpose   : Directed self-checking bench for cpu_sequencer, with an   |
// |             8-bit-address instance and a 2-bit-address instance.      |
// | Revision  : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_cpu_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance (ADDR_W = 8)
   logic        rst_n, start, im_ack, alu_done;
   logic [15:0] im_data;
   logic        busy, halted, illegal, im_req, alu_go, rf_we;
   logic [7:0]  pc, im_addr, alu_op;
   logic [3:0]  rf_ra, rf_rb, rf_wa;

   // Wrap instance (ADDR_W = 2)
   logic        rst_n2, start2, im_ack2, alu_done2;
   logic [15:0] im_data2;
   logic        busy2, halted2, illegal2, im_req2, alu_go2, rf_we2;
   logic [1:0]  pc2, im_addr2;
   logic [7:0]  alu_op2;
   logic [3:0]  rf_ra2, rf_rb2, rf_wa2;

   cpu_sequencer #(.ADDR_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .halted(halted),
      .illegal(illegal), .pc(pc), .im_req(im_req), .im_addr(im_addr),
      .im_ack(im_ack), .im_data(im_data), .rf_ra(rf_ra), .rf_rb(rf_rb),
      .alu_op(alu_op), .alu_go(alu_go), .alu_done(alu_done), .rf_we(rf_we),
      .rf_wa(rf_wa)
   );

   cpu_sequencer #(.ADDR_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n2), .start(start2), .busy(busy2), .halted(halted2),
      .illegal(illegal2), .pc(pc2), .im_req(im_req2), .im_addr(im_addr2),
      .im_ack(im_ack2), .im_data(im_data2), .rf_ra(rf_ra2), .rf_rb(rf_rb2),
      .alu_op(alu_op2), .alu_go(alu_go2), .alu_done(alu_done2), .rf_we(rf_we2),
      .rf_wa(rf_wa2)
   );

   logic [15:0] mem [0:255];
   int  mem_delay, alu_delay;
   bit  spur_decode;
   int  checks = 0, errors = 0;

   // Monitor state
   int         cyc, wait_cnt, alu_cnt, req_len;
   int         go_cnt, we_cnt, done_cyc, we_cyc;
   logic [3:0] last_wa, go_ra, go_rb;
   logic [7:0] go_op, prev_addr;
   bit         prev_req;
   int         stable_err;
   int         req_rise[$];
   int         req_lens[$];
   logic [7:0] ack_addr[$];
   logic [1:0] ack_addr2[$];

   // Memory/ALU responders and monitors; run on the falling edge so the
   // outputs of the current cycle are settled and inputs are set up for
   // the next rising edge.
   initial begin
      bit prev_ack, new_done;
      im_ack = 1'b0; im_data = 16'h0; alu_done = 1'b0;
      im_ack2 = 1'b0; im_data2 = 16'h0; alu_done2 = 1'b0;
      cyc = 0; wait_cnt = 0; alu_cnt = 0; req_len = 0; prev_req = 1'b0;
      prev_addr = 8'h0;
      forever begin
         @(negedge clk);
         cyc++;
         prev_ack = im_ack;
         // Monitors
         if (alu_go) begin
            go_cnt++;
            go_ra = rf_ra; go_rb = rf_rb; go_op = alu_op;
         end
         if (rf_we) begin
            we_cnt++; last_wa = rf_wa; we_cyc = cyc;
         end
         if (im_req && prev_req && (im_addr != prev_addr)) stable_err++;
         if (im_req && !prev_req) req_rise.push_back(cyc);
         if (im_req) req_len++;
         else if (req_len > 0) begin
            req_lens.push_back(req_len);
            req_len = 0;
         end
         prev_req  = im_req;
         prev_addr = im_addr;
         // Instruction memory
         im_ack = 1'b0;
         if (im_req) begin
            if (wait_cnt == mem_delay) begin
               im_ack  = 1'b1;
               im_data = mem[im_addr];
               ack_addr.push_back(im_addr);
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
         // ALU
         new_done = 1'b0;
         if (alu_go) alu_cnt = alu_delay;
         else if (alu_cnt > 0) begin
            alu_cnt--;
            if (alu_cnt == 0) begin
               new_done = 1'b1;
               done_cyc = cyc;
            end
         end
         // An ack in the previous cycle means this cycle is DECODE
         alu_done = new_done || (spur_decode && prev_ack);
         // Wrap instance: always-ready memory full of NOPs
         im_ack2  = im_req2;
         im_data2 = 16'h0000;
         if (im_req2) ack_addr2.push_back(im_addr2);
      end
   end

   task automatic clear_mon();
      #2;
      go_cnt = 0; we_cnt = 0; done_cyc = -100; we_cyc = -1; stable_err = 0;
      last_wa = 4'h0; go_ra = 4'h0; go_rb = 4'h0; go_op = 8'h0;
      req_rise.delete(); req_lens.delete(); ack_addr.delete(); ack_addr2.delete();
   endtask

   task automatic do_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_halt(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (halted) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rst_n2 = 1'b0; start = 1'b0; start2 = 1'b0;
      mem_delay = 0; alu_delay = 1; spur_decode = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, halted, illegal, im_req, alu_go, rf_we} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 000000", {busy, halted, illegal, im_req, alu_go, rf_we});
      end
      checks++;
      if ({pc, im_addr} !== 16'h0) begin
         errors++;
         $display("FAIL reset_pc: got pc=%0h im_addr=%0h expected 0", pc, im_addr);
      end
      checks++;
      if ({rf_ra, rf_rb, rf_wa, alu_op} !== 20'h0) begin
         errors++;
         $display("FAIL reset_fields: got %0h expected 0", {rf_ra, rf_rb, rf_wa, alu_op});
      end
      rst_n = 1'b1; rst_n2 = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, im_req} !== 2'b00) begin
         errors++;
         $display("FAIL idle_hold: got busy/im_req=%b expected 00", {busy, im_req});
      end
   endtask

   task automatic test_add_halt();
      bit ok;
      mem[0] = 16'h2101; mem[1] = 16'h00FF;
      mem_delay = 0; alu_delay = 1;
      clear_mon();
      do_start();
      wait_halt(50, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL add_halt_timeout: got halted=0 expected 1");
      end
      checks++;
      if (ack_addr.size() != 2 || ack_addr[0] !== 8'd0 || ack_addr[1] !== 8'd1) begin
         errors++;
         $display("FAIL add_fetch_addrs: got n=%0d expected 2 fetches at 0,1", ack_addr.size());
      end
      checks++;
      if ({go_ra, go_rb, go_op} !== {4'd1, 4'd2, 8'h01}) begin
         errors++;
         $display("FAIL add_decode: got ra=%0h rb=%0h op=%0h expected 1 2 01", go_ra, go_rb, go_op);
      end
      checks++;
      if (go_cnt != 1 || we_cnt != 1 || last_wa !== 4'd1) begin
         errors++;
         $display("FAIL add_go_we: got go=%0d we=%0d wa=%0h expected 1 1 1", go_cnt, we_cnt, last_wa);
      end
      checks++;
      if (halted !== 1'b1 || pc !== 8'd1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL add_halt_state: got halted=%b pc=%0h busy=%b expected 1 1 0", halted, pc, busy);
      end
      checks++;
      if (req_rise.size() < 2 || (req_rise[1] - req_rise[0]) != 5) begin
         errors++;
         $display("FAIL add_latency: got %0d cycles expected 5",
                  (req_rise.size() < 2) ? -1 : req_rise[1] - req_rise[0]);
      end
   endtask

   task automatic test_mem_delay();
      bit ok;
      mem[0] = 16'h2101; mem[1] = 16'h00FF;
      mem_delay = 3; alu_delay = 1;
      clear_mon();
      do_start();
      wait_halt(60, ok);
      checks++;
      if (!ok || stable_err != 0) begin
         errors++;
         $display("FAIL memdelay_stable: got halted=%b addr_changes=%0d expected 1 0", ok, stable_err);
      end
      checks++;
      if (req_lens.size() != 2 || req_lens[0] != 4 || req_lens[1] != 4) begin
         errors++;
         $display("FAIL memdelay_req_len: got n=%0d first=%0d expected 2 bursts of 4",
                  req_lens.size(), (req_lens.size() > 0) ? req_lens[0] : -1);
      end
      checks++;
      if (ack_addr.size() != 2 || we_cnt != 1 || go_cnt != 1) begin
         errors++;
         $display("FAIL memdelay_latch: got acks=%0d we=%0d go=%0d expected 2 1 1", ack_addr.size(), we_cnt, go_cnt);
      end
      mem_delay = 0;
   endtask

   task automatic test_alu_delay();
      bit ok;
      mem[0] = 16'h4301; mem[1] = 16'h00FF;
      alu_delay = 10; spur_decode = 1'b1;
      clear_mon();
      do_start();
      wait_halt(60, ok);
      spur_decode = 1'b0;
      checks++;
      if (!ok || go_cnt != 1) begin
         errors++;
         $display("FAIL aludelay_go: got halted=%b go_cycles=%0d expected 1 1", ok, go_cnt);
      end
      checks++;
      if (we_cnt != 1 || we_cyc != done_cyc + 1) begin
         errors++;
         $display("FAIL aludelay_we: got we=%0d at %0d expected 1 at %0d", we_cnt, we_cyc, done_cyc + 1);
      end
      checks++;
      if (last_wa !== 4'd3 || go_rb !== 4'd4) begin
         errors++;
         $display("FAIL aludelay_regs: got wa=%0h rb=%0h expected 3 4", last_wa, go_rb);
      end
      alu_delay = 1;
   endtask

   task automatic test_illegal();
      bit ok;
      mem[0] = 16'h0042; mem[1] = 16'h00FF;
      clear_mon();
      do_start();
      wait_halt(40, ok);
      checks++;
      if (!ok || illegal !== 1'b1 || pc !== 8'd1) begin
         errors++;
         $display("FAIL illegal_flag: got halted=%b illegal=%b pc=%0h expected 1 1 1", ok, illegal, pc);
      end
      checks++;
      if (go_cnt != 0 || we_cnt != 0) begin
         errors++;
         $display("FAIL illegal_no_exec: got go=%0d we=%0d expected 0 0", go_cnt, we_cnt);
      end
      mem[0] = 16'h00FF;
      do_start();
      checks++;
      if (illegal !== 1'b0 || pc !== 8'd0 || im_req !== 1'b1) begin
         errors++;
         $display("FAIL illegal_restart: got illegal=%b pc=%0h req=%b expected 0 0 1", illegal, pc, im_req);
      end
      wait_halt(20, ok);
      checks++;
      if (!ok || pc !== 8'd0 || illegal !== 1'b0) begin
         errors++;
         $display("FAIL illegal_rehalt: got halted=%b pc=%0h illegal=%b expected 1 0 0", ok, pc, illegal);
      end
   endtask

   task automatic test_wrap();
      logic [1:0] exp [0:5];
      bit ok;
      exp[0] = 2'd0; exp[1] = 2'd1; exp[2] = 2'd2;
      exp[3] = 2'd3; exp[4] = 2'd0; exp[5] = 2'd1;
      clear_mon();
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ack_addr2.size() >= 6) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wrap_timeout: got %0d fetches expected 6", ack_addr2.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (ack_addr2[i] !== exp[i]) begin
               errors++;
               $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, ack_addr2[i], exp[i]);
            end
         end
      end
      @(negedge clk); rst_n2 = 1'b0;
      @(negedge clk); rst_n2 = 1'b1;
   endtask

   task automatic test_reset_exec();
      bit ok;
      mem[0] = 16'h2101; mem[1] = 16'h00FF;
      alu_delay = 20;
      clear_mon();
      do_start();
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (go_cnt > 0) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rstexec_go_timeout: got go=0 expected 1");
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, halted, illegal, im_req, alu_go, rf_we} !== 6'b0 || pc !== 8'd0 ||
          {rf_ra, rf_rb, rf_wa, alu_op} !== 20'h0) begin
         errors++;
         $display("FAIL rstexec_async: got flags=%b pc=%0h fields=%0h expected 0 0 0",
                  {busy, halted, illegal, im_req, alu_go, rf_we}, pc, {rf_ra, rf_rb, rf_wa, alu_op});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      checks++;
      if (we_cnt != 0 || busy !== 1'b0 || im_req !== 1'b0 || halted !== 1'b0) begin
         errors++;
         $display("FAIL rstexec_idle: got we=%0d busy=%b req=%b halted=%b expected 0 0 0 0",
                  we_cnt, busy, im_req, halted);
      end
      alu_delay = 1;
   endtask

   initial begin
      test_reset();
      test_add_halt();
      test_mem_delay();
      test_alu_delay();
      test_illegal();
      test_wrap();
      test_reset_exec();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle fetch/decode/execute controller for the 16-bit lab CPU. It fetches instruction words from instruction memory over a req/ack handshake, latches them, and splits each into ALU control code [7:0], operand A register [11:8] and operand B register [15:12]. It then drives register-file read addresses, launches the ALU and writes the result back to operand A's register. It sits between instruction memory, register file and ALU, and owns the program counter.

## Interface
Parameters:
- ADDR_W, 8, program counter / instruction address width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; sampled in IDLE/HALTED to begin execution at address 0
- busy  out  1  high in every state except IDLE and HALTED
- halted  out  1  high in HALTED
- illegal  out  1  sticky; set on undefined ALU code, cleared on start
- pc  out  ADDR_W  current program counter
- im_req  out  1  instruction fetch request
- im_addr  out  ADDR_W  fetch address (= pc)
- im_ack  in  1  memory acknowledge; im_data valid this cycle
- im_data  in  16  instruction word
- rf_ra  out  4  register-file read address A (= instr[11:8])
- rf_rb  out  4  register-file read address B (= instr[15:12])
- alu_op  out  8  ALU control code (= instr[7:0])
- alu_go  out  1  one-cycle ALU launch pulse
- alu_done  in  1  ALU result valid
- rf_we  out  1  register-file write enable, one cycle
- rf_wa  out  4  write address (= instr[11:8])

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALTED.
- IDLE: on start=1, set pc=0 and clear illegal, then go to FETCH.
- FETCH: im_req=1, im_addr=pc held stable until im_ack. On the im_ack cycle, latch im_data into the instruction register, drop im_req the next cycle, and go to DECODE.
- DECODE (1 cycle): classify alu_op.
  - 0x01 ADD, 0x02 SUB, 0x03 AND, 0x04 OR, 0x05 XOR, 0x06 NOT go to EXEC.
  - 0x00 NOP: pc+1, go to FETCH.
  - 0xFF HALT: go to HALTED; pc is not incremented.
  - Any other code: set illegal, treat as NOP.
- EXEC: alu_go=1 in the first EXEC cycle only. Wait for alu_done; alu_done is ignored in the alu_go cycle. On alu_done, go to WB.
- WB (1 cycle): rf_we=1, rf_wa=instr[11:8], pc+1, go to FETCH.
- HALTED: hold until start=1, then behave as IDLE start (pc=0, illegal cleared, go to FETCH).
- pc increment wraps modulo 2^ADDR_W; there is no fault on wrap.
- rf_ra, rf_rb, alu_op and rf_wa are driven from the instruction register continuously. They are stable from DECODE through WB.

## Timing
- Reset values:
  - state=IDLE, pc=0, instruction register=0x0000.
  - im_req=0, im_addr=0, alu_go=0, rf_we=0.
  - busy=0, halted=0, illegal=0.
  - rf_ra=rf_rb=rf_wa=0, alu_op=0.
- Reset asserted mid-operation aborts immediately to the reset values. A pending fetch is dropped (im_req falls asynchronously), and no rf_we is issued.
- Minimum ALU instruction: FETCH 1 (ack in the first req cycle) + DECODE 1 + EXEC 2 + WB 1 = 5 cycles. NOP or illegal takes 2 cycles plus fetch wait.
- im_ack while im_req=0 is ignored. alu_done outside EXEC is ignored.
- start while busy is ignored.
- The cycle after rf_we=1 has im_req=1 with the new pc.

## Structure
- Shared package cpu_pkg holds:
  - ALU code constants (NOP, ADD..NOT, HALT).
  - The state enum.
  - Field bit positions (OPA_HI/LO=11/8, OPB_HI/LO=15/12, ALU_HI/LO=7/0).
- One sub-module, pc_reg: ADDR_W counter with async active-low reset, synchronous clear and increment-enable.
- FSM and instruction register are inline.

## Test plan
- Reset then start; memory acks in the same cycle; program [0x2101 ADD r1,r2; 0x00FF HALT]:
  - Required: im_addr 0 then 1; rf_ra=1, rf_rb=2, alu_op=0x01; one alu_go pulse; rf_we with rf_wa=1; halted=1 with pc=1.
  - ALU done one cycle after go: total 5 cycles from first im_req to second im_req.
- Memory ack delayed 3 cycles on each fetch:
  - Required: im_req and im_addr held stable for all 4 cycles; exactly one instruction latched per ack.
- alu_done delayed 10 cycles:
  - Required: alu_go high for exactly 1 cycle; rf_we only after alu_done.
  - A spurious alu_done in DECODE does not trigger WB.
- Instruction 0x0042 (undefined) followed by HALT:
  - Required: illegal=1 and stays set; no alu_go, no rf_we; pc advances to 1.
  - A restart via start clears illegal and sets pc=0.
- ADDR_W=2, program of four NOPs:
  - Required: pc wraps 3 to 0 and fetching continues from address 0.
- rst_n pulsed low during EXEC:
  - Required: all outputs go to reset values immediately; no rf_we afterward; state IDLE until start.
